delay_timer_sched: RTL and testbench

DELAY_TIMER_SCHED -- requirements
Module: delay_timer_sched

---
 rtl/delay_timer_sched.sv | 205 ++++++++++++++++++++
 tb/tb_delay_timer_sched.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_timer_sched.sv
// ---------------------------------------------------------------------------
// delay_timer_sched
//   NCH independent delay channels, each counting a programmable number of
//   timebase ticks (1us / 1ms / 100ms / 1s), plus a round-robin arbiter that
//   reports channel expiries one at a time over a valid/ack handshake.
//
// Ports
//   iClk           system clock, all registers update on its rising edge
//   rst_i          synchronous active-high reset
//   tick_1us..1s   single-cycle timebase pulses
//   start_i[c]     (re)start channel c with tb_sel_i / count_i fields
//   cancel_i[c]    return channel c to IDLE (wins over start_i[c])
//   tb_sel_i       2 bits per channel: 0=1us 1=1ms 2=100ms 3=1s
//   count_i        CNT_W bits per channel: delay in ticks
//   busy_o[c]      channel c is running
//   expired_o[c]   channel c has expired and waits for start/cancel
//   evt_valid_o    an expiry event is presented on evt_id_o
//   evt_id_o       index of the presented channel
//   evt_ack_i      consumes the presented event (ignored while not valid)
// ---------------------------------------------------------------------------
module delay_timer_sched #(
   parameter int NCH   = 4,
   parameter int CNT_W = 8
) (
   input  logic                 iClk,
   input  logic                 rst_i,
   input  logic                 tick_1us,
   input  logic                 tick_1ms,
   input  logic                 tick_100ms,
   input  logic                 tick_1s,
   input  logic [NCH-1:0]       start_i,
   input  logic [NCH-1:0]       cancel_i,
   input  logic [2*NCH-1:0]     tb_sel_i,
   input  logic [CNT_W*NCH-1:0] count_i,
   output logic [NCH-1:0]       busy_o,
   output logic [NCH-1:0]       expired_o,
   output logic                 evt_valid_o,
   output logic [1:0]           evt_id_o,
   input  logic                 evt_ack_i
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_EXP  = 2'b10
   } ch_state_t;

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   ch_state_t        r_state     [NCH];
   ch_state_t        w_state_nxt [NCH];
   logic [CNT_W-1:0] r_cnt       [NCH];
   logic [CNT_W-1:0] w_cnt_nxt   [NCH];
   logic [1:0]       r_tb        [NCH];
   logic [1:0]       w_tb_nxt    [NCH];
   logic [NCH-1:0]   r_pending;
   logic [NCH-1:0]   w_pending_nxt;
   logic [NCH-1:0]   w_tick;
   logic [NCH-1:0]   w_ack_clr;
   logic [NCH-1:0]   w_avail;
   logic             w_found;
   logic [1:0]       w_pick;
   logic             r_evt_valid;
   logic             w_evt_valid_nxt;
   logic [1:0]       r_evt_id;
   logic [1:0]       w_evt_id_nxt;
   logic [1:0]       r_rr_ptr;
   logic [1:0]       w_rr_ptr_nxt;

   // Route each channel's latched timebase to a single tick strobe
   always_comb begin
      w_tick = {NCH{1'b0}};
      for (int c = 0; c < NCH; c++) begin
         case (r_tb[c])
            2'd0:    w_tick[c] = tick_1us;
            2'd1:    w_tick[c] = tick_1ms;
            2'd2:    w_tick[c] = tick_100ms;
            2'd3:    w_tick[c] = tick_1s;
            default: w_tick[c] = 1'b0;
         endcase
      end
   end

   // Decode a valid acknowledge into a per-channel pending clear
   always_comb begin
      w_ack_clr = {NCH{1'b0}};
      for (int c = 0; c < NCH; c++) begin
         w_ack_clr[c] = r_evt_valid & evt_ack_i & (r_evt_id == 2'(c));
      end
   end

   // Channel next-state: cancel > start > tick decrement; expiry beats ack
   always_comb begin
      w_pending_nxt = r_pending;
      for (int c = 0; c < NCH; c++) begin
         w_state_nxt[c] = r_state[c];
         w_cnt_nxt[c]   = r_cnt[c];
         w_tb_nxt[c]    = r_tb[c];
         if (cancel_i[c]) begin
            w_state_nxt[c]   = ST_IDLE;
            w_cnt_nxt[c]     = CNT_ZERO;
            w_pending_nxt[c] = 1'b0;
         end else if (start_i[c]) begin
            // A tick in the start cycle is deliberately not counted
            w_tb_nxt[c]  = tb_sel_i[2*c +: 2];
            w_cnt_nxt[c] = count_i[CNT_W*c +: CNT_W];
            if (count_i[CNT_W*c +: CNT_W] == CNT_ZERO) begin
               w_state_nxt[c]   = ST_EXP;
               w_pending_nxt[c] = 1'b1;
            end else begin
               w_state_nxt[c]   = ST_RUN;
               w_pending_nxt[c] = 1'b0;
            end
         end else if ((r_state[c] == ST_RUN) && w_tick[c] && (r_cnt[c] != CNT_ZERO)) begin
            w_cnt_nxt[c] = r_cnt[c] - CNT_ONE;
            if (r_cnt[c] == CNT_ONE) begin
               w_state_nxt[c]   = ST_EXP;
               w_pending_nxt[c] = 1'b1;
            end else begin
               w_pending_nxt[c] = r_pending[c] & ~w_ack_clr[c];
            end
         end else begin
            w_pending_nxt[c] = r_pending[c] & ~w_ack_clr[c];
         end
      end
   end

   // Round-robin search from r_rr_ptr; channels being restarted or
   // cancelled this cycle are skipped so a stale event is never presented
   always_comb begin
      logic [1:0] w_idx;
      w_avail = r_pending & ~start_i & ~cancel_i;
      w_found = 1'b0;
      w_pick  = r_rr_ptr;
      w_idx   = r_rr_ptr;
      for (int k = 0; k < NCH; k++) begin
         w_idx   = r_rr_ptr + 2'(k);
         w_pick  = (!w_found && w_avail[w_idx]) ? w_idx : w_pick;
         w_found = w_found | w_avail[w_idx];
      end
   end

   // Arbiter next-state: hold until ack, drop on restart/cancel of the
   // presented channel, and only present again from the idle (low) cycle
   always_comb begin
      w_evt_valid_nxt = r_evt_valid;
      w_evt_id_nxt    = r_evt_id;
      w_rr_ptr_nxt    = r_rr_ptr;
      if (r_evt_valid) begin
         if (evt_ack_i) begin
            w_evt_valid_nxt = 1'b0;
            w_rr_ptr_nxt    = r_evt_id + 2'd1;
         end else if (start_i[r_evt_id] || cancel_i[r_evt_id]) begin
            w_evt_valid_nxt = 1'b0;
         end else begin
            w_evt_valid_nxt = 1'b1;
         end
      end else if (w_found) begin
         w_evt_valid_nxt = 1'b1;
         w_evt_id_nxt    = w_pick;
      end else begin
         w_evt_valid_nxt = 1'b0;
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge iClk) begin
      if (rst_i) begin
         for (int c = 0; c < NCH; c++) begin
            r_state[c] <= ST_IDLE;
            r_cnt[c]   <= CNT_ZERO;
            r_tb[c]    <= 2'd0;
         end
         r_pending   <= {NCH{1'b0}};
         r_evt_valid <= 1'b0;
         r_evt_id    <= 2'd0;
         r_rr_ptr    <= 2'd0;
      end else begin
         for (int c = 0; c < NCH; c++) begin
            r_state[c] <= w_state_nxt[c];
            r_cnt[c]   <= w_cnt_nxt[c];
            r_tb[c]    <= w_tb_nxt[c];
         end
         r_pending   <= w_pending_nxt;
         r_evt_valid <= w_evt_valid_nxt;
         r_evt_id    <= w_evt_id_nxt;
         r_rr_ptr    <= w_rr_ptr_nxt;
      end
   end

   // Status outputs decoded straight from the state registers
   always_comb begin
      busy_o    = {NCH{1'b0}};
      expired_o = {NCH{1'b0}};
      for (int c = 0; c < NCH; c++) begin
         busy_o[c]    = (r_state[c] == ST_RUN);
         expired_o[c] = (r_state[c] == ST_EXP);
      end
   end

   assign evt_valid_o = r_evt_valid;
   assign evt_id_o    = r_evt_id;

endmodule

// File: tb/tb_delay_timer_sched.sv
// ---------------------------------------------------------------------------
// tb_delay_timer_sched
//   Directed scenarios followed by a randomized run. A behavioural model of
//   the channels and event arbiter is advanced on every rising edge and
//   compared with the DUT outputs on every falling edge; directed scenarios
//   add literal expectations at chosen points.
// ---------------------------------------------------------------------------
module tb_delay_timer_sched;

   logic        iClk = 1'b0;
   logic        rst_i;
   logic        tick_1us, tick_1ms, tick_100ms, tick_1s;
   logic [3:0]  start_i, cancel_i;
   logic [7:0]  tb_sel_i;
   logic [31:0] count_i;
   logic        evt_ack_i;
   logic [3:0]  busy_o, expired_o;
   logic        evt_valid_o;
   logic [1:0]  evt_id_o;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   // model state: mode 0=idle 1=running 2=expired
   int m_mode [4];
   int m_left [4];
   int m_tb   [4];
   bit m_pend [4];
   bit m_valid;
   int m_id;
   int m_ptr;

   logic [9:0] exp_vec, act_vec;
   int ids[$];
   int seen, lows, min_gap, run_len, max_len;
   bit prev_v;

   delay_timer_sched #(.NCH(4), .CNT_W(8)) dut (
      .iClk(iClk), .rst_i(rst_i),
      .tick_1us(tick_1us), .tick_1ms(tick_1ms), .tick_100ms(tick_100ms), .tick_1s(tick_1s),
      .start_i(start_i), .cancel_i(cancel_i), .tb_sel_i(tb_sel_i), .count_i(count_i),
      .busy_o(busy_o), .expired_o(expired_o),
      .evt_valid_o(evt_valid_o), .evt_id_o(evt_id_o), .evt_ack_i(evt_ack_i)
   );

   always #5 iClk = ~iClk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: one call per rising edge, using the inputs of that cycle
   task automatic model_step();
      bit tk [4];
      bit old_pend [4];
      bit old_valid;
      int old_id;
      bit hit;
      int c;
      tk[0] = tick_1us; tk[1] = tick_1ms; tk[2] = tick_100ms; tk[3] = tick_1s;
      old_valid = m_valid;
      old_id    = m_id;
      for (int i = 0; i < 4; i++) old_pend[i] = m_pend[i];
      if (rst_i) begin
         for (int i = 0; i < 4; i++) begin
            m_mode[i] = 0; m_left[i] = 0; m_tb[i] = 0; m_pend[i] = 1'b0;
         end
         m_valid = 1'b0; m_id = 0; m_ptr = 0;
         return;
      end
      for (int i = 0; i < 4; i++) begin
         if (cancel_i[i]) begin
            m_mode[i] = 0; m_left[i] = 0; m_pend[i] = 1'b0;
         end else if (start_i[i]) begin
            m_tb[i]   = int'(tb_sel_i[2*i +: 2]);
            m_left[i] = int'(count_i[8*i +: 8]);
            m_mode[i] = (m_left[i] == 0) ? 2 : 1;
            m_pend[i] = (m_left[i] == 0);
         end else begin
            if (old_valid && evt_ack_i && old_id == i) m_pend[i] = 1'b0;
            if (m_mode[i] == 1 && tk[m_tb[i]]) begin
               m_left[i] = m_left[i] - 1;
               if (m_left[i] == 0) begin
                  m_mode[i] = 2;
                  m_pend[i] = 1'b1;
               end
            end
         end
      end
      if (old_valid) begin
         if (evt_ack_i) begin
            m_valid = 1'b0;
            m_ptr   = (old_id + 1) % 4;
         end else if (start_i[old_id] || cancel_i[old_id]) begin
            m_valid = 1'b0;
         end
      end else begin
         hit = 1'b0;
         for (int k = 0; k < 4; k++) begin
            c = (m_ptr + k) % 4;
            if (!hit && old_pend[c] && !start_i[c] && !cancel_i[c]) begin
               hit = 1'b1; m_valid = 1'b1; m_id = c;
            end
         end
      end
   endtask

   always @(posedge iClk) model_step();

   // Per-cycle comparison against the model
   always @(negedge iClk) begin
      if (cmp_en) begin
         for (int i = 0; i < 4; i++) begin
            exp_vec[9-i] = (m_mode[i] == 1);
            exp_vec[5-i] = (m_mode[i] == 2);
         end
         exp_vec[1:0] = m_valid ? 2'(m_id) : 2'b00;
         act_vec[9:6] = {busy_o[0], busy_o[1], busy_o[2], busy_o[3]};
         act_vec[5:2] = {expired_o[0], expired_o[1], expired_o[2], expired_o[3]};
         act_vec[1:0] = evt_valid_o ? evt_id_o : 2'b00;
         chk("model_outputs", {22'd0, act_vec}, {22'd0, exp_vec});
         chk("model_valid", {31'd0, evt_valid_o}, {31'd0, m_valid});
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge iClk);
         #1;
      end
   endtask

   task automatic start_ch(input int c, input int tb, input int cnt);
      start_i[c]         = 1'b1;
      tb_sel_i[2*c +: 2] = 2'(tb);
      count_i[8*c +: 8]  = 8'(cnt);
   endtask

   task automatic pulse_ms();
      tick_1ms = 1'b1;
      step(1);
      tick_1ms = 1'b0;
   endtask

   task automatic pulse_us();
      tick_1us = 1'b1;
      step(1);
      tick_1us = 1'b0;
   endtask

   task automatic cancel_all();
      cancel_i = 4'hF;
      step(1);
      cancel_i = 4'h0;
   endtask

   initial begin
      rst_i = 1'b1;
      tick_1us = 1'b0; tick_1ms = 1'b0; tick_100ms = 1'b0; tick_1s = 1'b0;
      start_i = 4'h0; cancel_i = 4'h0; tb_sel_i = 8'h00; count_i = 32'h0; evt_ack_i = 1'b0;

      // reset, with ticks pulsed while held
      step(1);
      cmp_en = 1'b1;
      {tick_1us, tick_1ms, tick_100ms, tick_1s} = 4'hF;
      step(1);
      {tick_1us, tick_1ms, tick_100ms, tick_1s} = 4'h0;
      step(1);
      chk("rst_busy", {28'd0, busy_o}, 32'd0);
      chk("rst_expired", {28'd0, expired_o}, 32'd0);
      chk("rst_valid", {31'd0, evt_valid_o}, 32'd0);
      chk("rst_id", {30'd0, evt_id_o}, 32'd0);
      rst_i = 1'b0;

      // channel 0, 1ms timebase, 3 ticks spaced 1000 cycles
      start_ch(0, 1, 3);
      step(1);
      start_i = 4'h0;
      chk("d36_busy_start", {31'd0, busy_o[0]}, 32'd1);
      for (int k = 1; k <= 3; k++) begin
         step(999);
         pulse_ms();
         if (k < 3) chk("d36_busy_mid", {31'd0, busy_o[0]}, 32'd1);
      end
      chk("d36_expired", {31'd0, expired_o[0]}, 32'd1);
      chk("d36_busy_end", {31'd0, busy_o[0]}, 32'd0);
      step(1);
      chk("d36_valid", {31'd0, evt_valid_o}, 32'd1);
      chk("d36_id", {30'd0, evt_id_o}, 32'd0);

      // restart channel 0 while its event is presented
      start_ch(0, 1, 5);
      step(1);
      start_i = 4'h0;
      chk("d39_valid_drop", {31'd0, evt_valid_o}, 32'd0);
      chk("d39_busy", {31'd0, busy_o[0]}, 32'd1);
      for (int k = 1; k <= 5; k++) begin
         step(2);
         pulse_ms();
         if (k == 4) chk("d39_busy_4", {31'd0, busy_o[0]}, 32'd1);
      end
      chk("d39_expired_5", {31'd0, expired_o[0]}, 32'd1);
      step(1);
      chk("d39_valid", {31'd0, evt_valid_o}, 32'd1);
      evt_ack_i = 1'b1;
      step(1);
      evt_ack_i = 1'b0;
      chk("d39_ack_drop", {31'd0, evt_valid_o}, 32'd0);

      // channels 1..3 with count 0 together, ack every presentation
      start_ch(1, 2, 0); start_ch(2, 3, 0); start_ch(3, 0, 0);
      step(1);
      start_i = 4'h0;
      ids.delete(); prev_v = 1'b0; lows = 0; min_gap = 99;
      for (int i = 0; i < 30; i++) begin
         step(1);
         if (evt_valid_o) begin
            if (!prev_v) begin
               ids.push_back(int'(evt_id_o));
               if (ids.size() > 1 && lows < min_gap) min_gap = lows;
            end
            lows = 0;
         end else begin
            lows++;
         end
         evt_ack_i = evt_valid_o;
         prev_v    = evt_valid_o;
      end
      evt_ack_i = 1'b0;
      chk("d37_count", ids.size(), 32'd3);
      if (ids.size() == 3) begin
         chk("d37_first", ids[0], 32'd1);
         chk("d37_second", ids[1], 32'd2);
         chk("d37_third", ids[2], 32'd3);
      end
      chk("d37_gap", {31'd0, min_gap >= 1}, 32'd1);
      cancel_all();

      // simultaneous start and cancel on running channel 2
      start_ch(2, 0, 10);
      step(1);
      start_i = 4'h0;
      chk("d38_busy_run", {31'd0, busy_o[2]}, 32'd1);
      step(2);
      start_ch(2, 0, 1);
      cancel_i[2] = 1'b1;
      step(1);
      start_i = 4'h0; cancel_i = 4'h0;
      chk("d38_busy", {31'd0, busy_o[2]}, 32'd0);
      chk("d38_expired", {31'd0, expired_o[2]}, 32'd0);
      seen = 0;
      tick_1us = 1'b1;
      for (int i = 0; i < 40; i++) begin
         step(1);
         if (evt_valid_o) seen++;
      end
      tick_1us = 1'b0;
      chk("d38_no_event", seen, 32'd0);

      // ack held high, channels 1 and 3 expire in the same cycle
      evt_ack_i = 1'b1;
      start_ch(1, 0, 2); start_ch(3, 0, 2);
      step(1);
      start_i = 4'h0;
      ids.delete(); prev_v = 1'b0; run_len = 0; max_len = 0;
      for (int i = 0; i < 20; i++) begin
         tick_1us = (i < 2);
         step(1);
         if (evt_valid_o) begin
            if (!prev_v) ids.push_back(int'(evt_id_o));
            run_len++;
            if (run_len > max_len) max_len = run_len;
         end else begin
            run_len = 0;
         end
         prev_v = evt_valid_o;
      end
      tick_1us = 1'b0;
      evt_ack_i = 1'b0;
      chk("d41_count", ids.size(), 32'd2);
      if (ids.size() == 2) begin
         chk("d41_first", ids[0], 32'd1);
         chk("d41_second", ids[1], 32'd3);
      end
      chk("d41_once", max_len, 32'd1);
      cancel_all();

      // one-cycle reset with channel 1's event presented
      start_ch(1, 0, 2);
      step(1);
      start_i = 4'h0;
      pulse_us();
      pulse_us();
      step(1);
      chk("d40_valid_before", {31'd0, evt_valid_o}, 32'd1);
      chk("d40_id_before", {30'd0, evt_id_o}, 32'd1);
      rst_i = 1'b1;
      step(1);
      rst_i = 1'b0;
      chk("d40_outputs", {22'd0, busy_o, expired_o, evt_valid_o, evt_id_o[0]}, 32'd0);
      chk("d40_id", {30'd0, evt_id_o}, 32'd0);
      seen = 0;
      for (int i = 0; i < 10000; i++) begin
         {tick_1us, tick_1ms, tick_100ms, tick_1s} = 4'($urandom_range(0, 15));
         step(1);
         if (evt_valid_o) seen++;
      end
      {tick_1us, tick_1ms, tick_100ms, tick_1s} = 4'h0;
      chk("d40_no_event", seen, 32'd0);

      // randomized run checked by the model
      for (int i = 0; i < 20000; i++) begin
         for (int c = 0; c < 4; c++) begin
            start_i[c]         = ($urandom_range(0, 99) < 3);
            cancel_i[c]        = ($urandom_range(0, 199) == 0);
            tb_sel_i[2*c +: 2] = 2'($urandom_range(0, 3));
            count_i[8*c +: 8]  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                                             : 8'($urandom_range(0, 6));
         end
         tick_1us   = ($urandom_range(0, 3) == 0);
         tick_1ms   = ($urandom_range(0, 3) == 0);
         tick_100ms = ($urandom_range(0, 3) == 0);
         tick_1s    = ($urandom_range(0, 3) == 0);
         evt_ack_i  = $urandom_range(0, 1) == 1;
         rst_i      = ($urandom_range(0, 4999) == 0);
         step(1);
      end
      rst_i = 1'b0; start_i = 4'h0; cancel_i = 4'h0; evt_ack_i = 1'b0;
      {tick_1us, tick_1ms, tick_100ms, tick_1s} = 4'h0;
      step(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
